// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Data-memory responder: one outstanding load/store, fixed latency, byte lanes and extension.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_wen;
    logic [31:0] cap_addr;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH];

    logic        eff_wen;
    logic [31:0] eff_addr;
    logic [2:0]  eff_funct3;
    logic [31:0] eff_wdata;
    logic        misalign_err;
    logic        range_err;
    logic        funct3_err;
    logic        acc_err;
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [3:0]  byte_en;
    logic [31:0] store_data;
    logic        commit;
    logic        wr_en;
    logic [31:0] rdata_nxt;

    assign req_ready_o = (state == IDLE);

    // With LATENCY=1 the commit edge is also the capture edge, so the live inputs are used there.
    always_comb begin
        eff_wen    = cap_wen;
        eff_addr   = cap_addr;
        eff_funct3 = cap_funct3;
        eff_wdata  = cap_wdata;
        if (state == IDLE) begin
            eff_wen    = req_wen_i;
            eff_addr   = req_addr_i;
            eff_funct3 = req_funct3_i;
            eff_wdata  = req_wdata_i;
        end
    end

    always_comb begin
        misalign_err = 1'b0;
        case (eff_funct3[1:0])
            2'b01:   misalign_err = eff_addr[0];
            2'b10:   misalign_err = (eff_addr[1:0] != 2'b00);
            default: misalign_err = 1'b0;
        endcase
        range_err = ({2'b00, eff_addr[31:2]} >= DEPTH_W);
        if (eff_wen)
            funct3_err = (eff_funct3 >= 3'b011);
        else
            funct3_err = (eff_funct3 == 3'b011) || (eff_funct3 == 3'b110) || (eff_funct3 == 3'b111);
        acc_err = misalign_err || range_err || funct3_err;
    end

    assign idx  = eff_addr[AW+1:2];
    assign word = mem[idx];

    always_comb begin
        sel_byte = word[7:0];
        case (eff_addr[1:0])
            2'b00: sel_byte = word[7:0];
            2'b01: sel_byte = word[15:8];
            2'b10: sel_byte = word[23:16];
            2'b11: sel_byte = word[31:24];
        endcase
        sel_half = eff_addr[1] ? word[31:16] : word[15:0];
        case (eff_funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_data = word;
            3'b100:  load_data = {24'h0, sel_byte};
            3'b101:  load_data = {16'h0, sel_half};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        byte_en    = 4'b0000;
        store_data = 32'h0;
        case (eff_funct3)
            3'b000: begin
                byte_en    = 4'b0001 << eff_addr[1:0];
                store_data = {4{eff_wdata[7:0]}};
            end
            3'b001: begin
                byte_en    = eff_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{eff_wdata[15:0]}};
            end
            3'b010: begin
                byte_en    = 4'b1111;
                store_data = eff_wdata;
            end
            default: begin
                byte_en    = 4'b0000;
                store_data = 32'h0;
            end
        endcase
    end

    assign commit    = ((state == IDLE) && req_valid_i && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == 4'd1));
    assign wr_en     = commit && eff_wen && !acc_err && !rst_i;
    assign rdata_nxt = (eff_wen || acc_err) ? 32'h0 : load_data;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
            cap_wen     <= 1'b0;
            cap_addr    <= 32'h0;
            cap_funct3  <= 3'b000;
            cap_wdata   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        cap_wen    <= req_wen_i;
                        cap_addr   <= req_addr_i;
                        cap_funct3 <= req_funct3_i;
                        cap_wdata  <= req_wdata_i;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= rdata_nxt;
                            rsp_err_o   <= acc_err;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt         <= 4'd0;
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= rdata_nxt;
                        rsp_err_o   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Directed bench for dmem_responder with LATENCY=1 and LATENCY=4 instances.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] wdata = 32'h0;
    logic        v1 = 1'b0, v4 = 1'b0, r1 = 1'b0, r4 = 1'b0;
    logic        rdy1, rv1, er1, rdy4, rv4, er4;
    logic [31:0] rd1, rd4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(rdy1),
        .req_wen_i(wen), .req_addr_i(addr), .req_funct3_i(funct3), .req_wdata_i(wdata),
        .rsp_valid_o(rv1), .rsp_ready_i(r1), .rsp_rdata_o(rd1), .rsp_err_o(er1)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v4), .req_ready_o(rdy4),
        .req_wen_i(wen), .req_addr_i(addr), .req_funct3_i(funct3), .req_wdata_i(wdata),
        .rsp_valid_o(rv4), .rsp_ready_i(r4), .rsp_rdata_o(rd4), .rsp_err_o(er4)
    );

    // A request left pending at one negedge must still be offered at the next.
    logic pend1 = 1'b0, pend4 = 1'b0;
    always @(negedge clk) begin
        if (!rst && pend1) begin
            n_cmp++;
            if (v1 !== 1'b1) begin n_bad++; $display("FAIL valid_hold_lat1: valid=%b required 1", v1); end
        end
        if (!rst && pend4) begin
            n_cmp++;
            if (v4 !== 1'b1) begin n_bad++; $display("FAIL valid_hold_lat4: valid=%b required 1", v4); end
        end
        pend1 = v1 && !rdy1;
        pend4 = v4 && !rdy4;
    end

    task automatic txn(input bit use4, input bit w, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] d, output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        wen = w; addr = a; funct3 = f3; wdata = d;
        if (use4) begin v4 = 1'b1; r4 = 1'b1; end
        else      begin v1 = 1'b1; r1 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0;
        lat = 1;
        while (!(use4 ? rv4 : rv1) && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rdata = use4 ? rd4 : rd1;
        err   = use4 ? er4 : er1;
        if (lat >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: no response after %0d cycles, addr %h", lat, a);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL reset_ready1: got %b want 1", rdy1); end
        n_cmp++; if (rv1 !== 1'b0)  begin n_bad++; $display("FAIL reset_valid1: got %b want 0", rv1); end
        n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h want 0", rd1); end
        n_cmp++; if (er1 !== 1'b0)  begin n_bad++; $display("FAIL reset_err1: got %b want 0", er1); end
        n_cmp++; if (rdy4 !== 1'b1) begin n_bad++; $display("FAIL reset_ready4: got %b want 1", rdy4); end
        n_cmp++; if (rv4 !== 1'b0)  begin n_bad++; $display("FAIL reset_valid4: got %b want 0", rv4); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL sw_latency: got %0d want 1", lat); end
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_rsp: got err %b rdata %h want 0/0", er, rd); end
        txn(0, 0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lw_latency: got %0d want 1", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL lw_data: got %h err %b want deadbeef 0", rd, er); end
    endtask

    task automatic test_extension();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [2:0]  fn [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            txn(0, 0, ad[i], fn[i], 32'h0, rd, er, lat);
            n_cmp++;
            if (rd !== ex[i] || er !== 1'b0) begin
                n_bad++; $display("FAIL ext_load_%0d: got %h err %b want %h 0", i, rd, er, ex[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1, 32'h11, 3'b000, 32'hFFFFFF55, rd, er, lat);
        txn(0, 1, 32'h12, 3'b001, 32'hFFFF1234, rd, er, lat);
        txn(0, 0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h123455EF) begin n_bad++; $display("FAIL partial_store: got %h want 123455ef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        txn(0, 0, 32'h11, 3'b010, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lw_misalign: got err %b rdata %h want 1 0", er, rd); end
        txn(0, 1, 32'h13, 3'b001, 32'h0000FFFF, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL sh_misalign: got err %b want 1", er); end
        txn(0, 1, 32'h10, 3'b011, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL store_funct3: got err %b want 1", er); end
        txn(0, 0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h123455EF) begin n_bad++; $display("FAIL err_no_write: got %h want 123455ef", rd); end
        txn(0, 0, 32'h1000, 3'b010, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lw_range: got err %b rdata %h want 1 0", er, rd); end
        txn(0, 0, 32'hFFC, 3'b010, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lw_last_word: got err %b want 0", er); end
        txn(0, 0, 32'h10, 3'b111, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL load_funct3: got err %b rdata %h want 1 0", er, rd); end
    endtask

    task automatic test_latency4();
        logic [31:0] rd; logic er; int lat;
        txn(1, 1, 32'h30, 3'b010, 32'hCAFEF00D, rd, er, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL lat4_store: got %0d want 4", lat); end
        @(negedge clk);
        wen = 1'b0; addr = 32'h30; funct3 = 3'b010; v4 = 1'b1; r4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0; wen = 1'b1; addr = 32'h31; funct3 = 3'b111;
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (rv4 !== 1'b0 || rdy4 !== 1'b0) begin n_bad++; $display("FAIL lat4_wait_%0d: got valid %b ready %b want 0 0", k, rv4, rdy4); end
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if (rv4 !== 1'b1 || rd4 !== 32'hCAFEF00D || er4 !== 1'b0) begin
            n_bad++; $display("FAIL lat4_rsp: got valid %b rdata %h err %b want 1 cafef00d 0", rv4, rd4, er4);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (rv4 !== 1'b1 || rd4 !== 32'hCAFEF00D || er4 !== 1'b0 || rdy4 !== 1'b0) begin
                n_bad++; $display("FAIL lat4_hold_%0d: got valid %b rdata %h err %b ready %b", k, rv4, rd4, er4, rdy4);
            end
        end
        r4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rv4 !== 1'b0 || rdy4 !== 1'b1) begin n_bad++; $display("FAIL lat4_release: got valid %b ready %b want 0 1", rv4, rdy4); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat;
        txn(1, 1, 32'h20, 3'b010, 32'h11111111, rd, er, lat);
        @(negedge clk);
        wen = 1'b1; addr = 32'h20; funct3 = 3'b010; wdata = 32'hA5A5A5A5; v4 = 1'b1; r4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (rdy4 !== 1'b1 || rv4 !== 1'b0 || rd4 !== 32'h0 || er4 !== 1'b0) begin
            n_bad++; $display("FAIL rst_wait_outputs: got ready %b valid %b rdata %h err %b", rdy4, rv4, rd4, er4);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rv4 !== 1'b0) begin n_bad++; $display("FAIL rst_wait_no_rsp: got valid %b want 0", rv4); end
        txn(1, 0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h11111111) begin n_bad++; $display("FAIL rst_wait_ram: got %h want 11111111", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_extension();
        test_partial_store();
        test_errors();
        test_latency4();
        test_reset_in_wait();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the MEM-stage data-memory interface; the pipeline's mem_ren/mem_wen decode is the initiator side.
- Accepts one load or store request at a time over a valid/ready handshake and models a word-organised data RAM with LATENCY cycles of access delay.
- Performs byte-lane selection on stores and sign/zero extension on loads.
- Returns one response per request, flagging misaligned, out-of-range and illegal-funct3 accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; power of two.
- LATENCY, 1, cycles from request acceptance to rsp_valid_o; legal range 1..15.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  initiator has a request.
- req_ready_o  output  1  responder can accept a request.
- req_wen_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_funct3_i  input  3  RV32I load/store funct3.
- req_wdata_i  input  32  store data, right-aligned.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  initiator consumes the response.
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
- rsp_err_o  output  1  access faulted; no RAM write occurred.

Behaviour:
- Reset: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i=1, capture wen/addr/funct3/wdata and evaluate the error condition.
  - LATENCY=1: go to RESP.
  - LATENCY>1: load counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready_o=0. Decrement the counter each cycle; when it reaches 1, go to RESP on the next edge.
- Response timing: a request accepted at edge N raises rsp_valid_o from edge N+LATENCY.
- Commit point: RAM read or write happens on the edge that enters RESP, from the captured fields.
  - rsp_rdata_o and rsp_err_o are registered on that edge.
  - Both hold stable while in RESP.
- RESP: rsp_valid_o=1, req_ready_o=0. When rsp_ready_i=1, go to IDLE and drop rsp_valid_o on the next edge. Otherwise hold indefinitely.
- req_ready_o is combinational from state only. A new request is accepted no sooner than one cycle after the response handshake; there is no back-to-back overlap.
- Word index = addr[31:2]; byte lane = addr[1:0].
- Loads:
  - LB (000): sign-extend the selected byte.
  - LH (001): sign-extend the half at addr[1].
  - LW (010): full word.
  - LBU (100): zero-extend the selected byte.
  - LHU (101): zero-extend the selected half.
- Stores:
  - SB (000): write wdata[7:0] to the addressed lane only.
  - SH (001): write wdata[15:0] to half addr[1] only.
  - SW (010): write all 4 lanes.
  - All other bytes of the word are unchanged.
- Errors set rsp_err_o=1, suppress any RAM write and force rsp_rdata_o=0. Error conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:2] >= DEPTH;
  - load funct3 in {011,110,111};
  - store funct3 >= 011.
- Stores with no error return rsp_err_o=0 and rsp_rdata_o=0.
- Input changes while not in IDLE are ignored; the captured copy is used.
- Reset in WAIT: the pending store is discarded and the RAM is unmodified.
- Reset in RESP: the response is dropped and the already-committed write remains.
- Assertion: req_valid_i must stay high until accepted; the bench checks this protocol rule, the RTL does not enforce it.

Test Plan:
- LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> each rsp_valid_o exactly 1 cycle after accept; load returns 0xDEADBEEF, err=0.
- Byte/half extension on word 0x10=0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x10 -> 0xFFFFBEEF
  - LHU 0x12 -> 0x0000DEAD
- Partial stores: SB 0x11 data 0x55 then SH 0x12 data 0x1234 on 0xDEADBEEF -> LW 0x10 returns 0x123455EF.
- Errors:
  - LW 0x11 -> err=1, rdata=0.
  - SH 0x13 -> err=1; a following LW confirms the word is unchanged.
  - LW at word DEPTH -> err=1.
  - Load funct3=111 -> err=1.
- LATENCY=4 with rsp_ready_i held low 3 cycles after rsp_valid_o:
  - rsp_valid_o rises 4 cycles after accept;
  - data and err stay stable;
  - req_ready_o=0 throughout;
  - req_ready_o=1 the cycle after the handshake.
- LATENCY=4: assert rst_i 2 cycles after accepting SW 0x20 data 0xA5A5A5A5, with word 0x20 preloaded to 0x11111111 -> all outputs return to reset values; LW 0x20 afterwards returns 0x11111111.
